hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
//   Pipeline hazard/stall controller for the 5-stage core; counterpart to the forwarding unit. Covers
//   hazards forwarding cannot resolve: load-use (stall PC and IF/ID, bubble into ID/EX), taken-branch
//   IF/ID flush, and a full-pipeline freeze while the data memory handshake is outstanding.
//   Sits beside ID; drives PC write-enable, IF/ID write/flush, ID/EX bubble, global freeze.
// PARAMETERS
//   LU_CYCLES    1     bubble cycles per load-use hazard (1..15)
//   MEM_TIMEOUT  255   freeze cycles before mem_timeout_o sets (1..65535)
//   CNT_W        16    width of stall_cnt_o
// PORTS
//   clk_i              in   1      clock
//   rst_i              in   1      synchronous reset, active-high
//   ID_EX_MemRead_i    in   1      instruction in EX is a load
//   ID_EX_RegisterRt_i in   5      load destination in EX
//   IF_ID_RegisterRs_i in   5      rs of instruction in ID
//   IF_ID_RegisterRt_i in   5      rt of instruction in ID
//   branch_taken_i     in   1      branch in ID resolved taken
//   mem_req_i          in   1      MEM stage issues data access this cycle
//   mem_ack_i          in   1      data memory completes access
//   pc_write_o         out  1      PC load enable
//   IF_ID_write_o      out  1      IF/ID register load enable
//   IF_flush_o         out  1      clear IF/ID to nop
//   ID_EX_bubble_o     out  1      force ID/EX control bits to zero
//   freeze_o           out  1      hold ID/EX, EX/MEM, MEM/WB
//   mem_timeout_o      out  1      sticky: MEM_WAIT exceeded MEM_TIMEOUT
//   stall_cnt_o        out  CNT_W  saturating count of stalled cycles
// BEHAVIOUR
//   States RUN, LU_STALL, MEM_WAIT; 4-bit lu_cnt; 16-bit wait_cnt. Outputs combinational from state+inputs.
//   lu_hit = ID_EX_MemRead_i && Rt!=0 && (Rt==IF_ID_Rs || Rt==IF_ID_Rt).
//   mem_hold = mem_req_i && !mem_ack_i. Priority: mem_hold > lu_hit > branch_taken_i.
//   RUN:
//     - mem_hold: freeze_o=1, pc_write_o=0, IF_ID_write_o=0, bubble=0, flush=0; -> MEM_WAIT, wait_cnt=1.
//     - else lu_hit: pc_write_o=0, IF_ID_write_o=0, ID_EX_bubble_o=1, flush=0 (branch ignored, re-seen
//       next cycle); LU_CYCLES==1 stay RUN, else -> LU_STALL with lu_cnt=LU_CYCLES-1.
//     - else branch_taken_i: IF_flush_o=1, pc/IF_ID write=1.
//     - else all enables 1, flush/bubble/freeze 0.
//   LU_STALL: same outputs as lu_hit regardless of inputs (mem_hold still wins -> MEM_WAIT, lu_cnt kept);
//     lu_cnt decrements, -> RUN when lu_cnt reaches 0 this cycle (lu_cnt==1).
//   MEM_WAIT: freeze outputs as above while !mem_ack_i; wait_cnt increments, saturates at MEM_TIMEOUT,
//     sets mem_timeout_o when wait_cnt==MEM_TIMEOUT. On mem_ack_i: outputs evaluated as RUN this cycle
//     (ack cycle is not stalled), -> LU_STALL if lu_cnt!=0 else RUN (or per RUN rules).
//   stall_cnt_o +1 on any cycle with pc_write_o==0; saturates at all-ones, no wrap.
//   mem_ack_i without mem_req_i ignored. Branch during freeze applied on release (ID holds it).
//   Reset: state=RUN, lu_cnt=0, wait_cnt=0, stall_cnt_o=0, mem_timeout_o=0; during rst_i outputs:
//     pc_write_o=1, IF_ID_write_o=1, flush/bubble/freeze=0. Reset mid-stall aborts it next cycle.
// TESTING
//   lw $2 then add $3,$2,$4: cycle after lw in EX -> pc_write_o=0, ID_EX_bubble_o=1 one cycle, stall_cnt=1.
//   Load to $0 matching rs=0 -> no stall; load $5, ID uses $6/$7 -> no stall.
//   LU_CYCLES=3, hit -> bubble exactly 3 consecutive cycles then enables high.
//   mem_req_i=1, ack after 4 cycles -> freeze_o=1 cycles 0..3, low on ack cycle; stall_cnt=4.
//   branch_taken_i with lu_hit same cycle -> flush=0, bubble=1; next cycle flush=1.
//   MEM_TIMEOUT=8, no ack -> mem_timeout_o=1 on cycle 8, held; rst_i clears all to reset values.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller for the 5-stage core.
// Handles load-use stalls, taken-branch flushes and data-memory freezes.
module hazard_stall_ctrl #(
    parameter int LU_CYCLES   = 1,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ID_EX_MemRead_i,
    input  logic [4:0]       ID_EX_RegisterRt_i,
    input  logic [4:0]       IF_ID_RegisterRs_i,
    input  logic [4:0]       IF_ID_RegisterRt_i,
    input  logic             branch_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    output logic             pc_write_o,
    output logic             IF_ID_write_o,
    output logic             IF_flush_o,
    output logic             ID_EX_bubble_o,
    output logic             freeze_o,
    output logic             mem_timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam logic [3:0]  LU_INIT = 4'(LU_CYCLES - 1);
    localparam logic [15:0] TO_MAX  = 16'(MEM_TIMEOUT);

    state_t            state_q, state_d;
    logic [3:0]        lu_cnt_q, lu_cnt_d;
    logic [15:0]       wait_cnt_q, wait_cnt_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  stall_cnt_q;

    logic lu_hit;
    logic mem_hold;

    // Decisions a RUN-state cycle would make; reused on memory release.
    state_t      r_state;
    logic [3:0]  r_lu_cnt;
    logic [15:0] r_wait_cnt;
    logic        r_timeout;
    logic        r_pc_write;
    logic        r_ifid_write;
    logic        r_flush;
    logic        r_bubble;
    logic        r_freeze;

    // Hazard detection shared by every state.
    always_comb begin
        lu_hit = ID_EX_MemRead_i
              && (ID_EX_RegisterRt_i != 5'd0)
              && ((ID_EX_RegisterRt_i == IF_ID_RegisterRs_i)
               || (ID_EX_RegisterRt_i == IF_ID_RegisterRt_i));
        mem_hold = mem_req_i && !mem_ack_i;
    end

    // RUN rules: mem_hold beats load-use, load-use beats branch flush.
    always_comb begin
        r_state      = RUN;
        r_lu_cnt     = lu_cnt_q;
        r_wait_cnt   = wait_cnt_q;
        r_timeout    = timeout_q;
        r_pc_write   = 1'b1;
        r_ifid_write = 1'b1;
        r_flush      = 1'b0;
        r_bubble     = 1'b0;
        r_freeze     = 1'b0;
        if (mem_hold) begin
            r_pc_write   = 1'b0;
            r_ifid_write = 1'b0;
            r_freeze     = 1'b1;
            r_state      = MEM_WAIT;
            r_wait_cnt   = 16'd1;
            if (TO_MAX == 16'd1) begin
                r_timeout = 1'b1;
            end
        end else if (lu_hit) begin
            r_pc_write   = 1'b0;
            r_ifid_write = 1'b0;
            r_bubble     = 1'b1;
            if (LU_CYCLES > 1) begin
                r_state  = LU_STALL;
                r_lu_cnt = LU_INIT;
            end
        end else if (branch_taken_i) begin
            r_flush = 1'b1;
        end
    end

    // Next-state and output selection per state; reset forces run enables.
    always_comb begin
        state_d        = state_q;
        lu_cnt_d       = lu_cnt_q;
        wait_cnt_d     = wait_cnt_q;
        timeout_d      = timeout_q;
        pc_write_o     = 1'b1;
        IF_ID_write_o  = 1'b1;
        IF_flush_o     = 1'b0;
        ID_EX_bubble_o = 1'b0;
        freeze_o       = 1'b0;
        unique case (state_q)
            RUN: begin
                state_d        = r_state;
                lu_cnt_d       = r_lu_cnt;
                wait_cnt_d     = r_wait_cnt;
                timeout_d      = r_timeout;
                pc_write_o     = r_pc_write;
                IF_ID_write_o  = r_ifid_write;
                IF_flush_o     = r_flush;
                ID_EX_bubble_o = r_bubble;
                freeze_o       = r_freeze;
            end
            LU_STALL: begin
                if (mem_hold) begin
                    // Freeze wins; the remaining bubble count survives it.
                    state_d       = MEM_WAIT;
                    wait_cnt_d    = r_wait_cnt;
                    timeout_d     = r_timeout;
                    pc_write_o    = 1'b0;
                    IF_ID_write_o = 1'b0;
                    freeze_o      = 1'b1;
                end else begin
                    pc_write_o     = 1'b0;
                    IF_ID_write_o  = 1'b0;
                    ID_EX_bubble_o = 1'b1;
                    lu_cnt_d       = lu_cnt_q - 4'd1;
                    if (lu_cnt_q <= 4'd1) begin
                        lu_cnt_d = 4'd0;
                        state_d  = RUN;
                    end
                end
            end
            MEM_WAIT: begin
                if (mem_ack_i) begin
                    // Ack cycle itself is not stalled.
                    pc_write_o     = r_pc_write;
                    IF_ID_write_o  = r_ifid_write;
                    IF_flush_o     = r_flush;
                    ID_EX_bubble_o = r_bubble;
                    freeze_o       = r_freeze;
                    wait_cnt_d     = r_wait_cnt;
                    timeout_d      = r_timeout;
                    if (lu_cnt_q != 4'd0) begin
                        state_d  = LU_STALL;
                        lu_cnt_d = lu_cnt_q;
                    end else begin
                        state_d  = r_state;
                        lu_cnt_d = r_lu_cnt;
                    end
                end else begin
                    pc_write_o    = 1'b0;
                    IF_ID_write_o = 1'b0;
                    freeze_o      = 1'b1;
                    if (wait_cnt_q < TO_MAX) begin
                        wait_cnt_d = wait_cnt_q + 16'd1;
                    end
                    if (wait_cnt_d == TO_MAX) begin
                        timeout_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
        if (rst_i) begin
            pc_write_o     = 1'b1;
            IF_ID_write_o  = 1'b1;
            IF_flush_o     = 1'b0;
            ID_EX_bubble_o = 1'b0;
            freeze_o       = 1'b0;
        end
    end

    // State, counters and sticky timeout flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= RUN;
            lu_cnt_q   <= 4'd0;
            wait_cnt_q <= 16'd0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            lu_cnt_q   <= lu_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    // Saturating count of cycles where the PC was held.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else if (!pc_write_o && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign mem_timeout_o = timeout_q;
    assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl.
// Two instances: defaults (A) and LU_CYCLES=3/MEM_TIMEOUT=8/CNT_W=4 (B).
module tb_hazard_stall_ctrl;

    logic clk;
    logic rst;
    logic mr;
    logic [4:0] ert, rs, rt;
    logic br, req, ack;

    logic a_pc, a_ifid, a_fl, a_bub, a_frz, a_to;
    logic [15:0] a_cnt;
    logic b_pc, b_ifid, b_fl, b_bub, b_frz, b_to;
    logic [3:0] b_cnt;

    typedef struct {
        bit          sel;
        logic [5:0]  o;
        logic [15:0] c;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    // {pc_write, IF_ID_write, flush, bubble, freeze, timeout}
    localparam logic [5:0] RUNV = 6'b110000;
    localparam logic [5:0] LUV  = 6'b000100;
    localparam logic [5:0] FRZ  = 6'b000010;
    localparam logic [5:0] FLV  = 6'b111000;

    hazard_stall_ctrl u_a (
        .clk_i(clk), .rst_i(rst),
        .ID_EX_MemRead_i(mr), .ID_EX_RegisterRt_i(ert),
        .IF_ID_RegisterRs_i(rs), .IF_ID_RegisterRt_i(rt),
        .branch_taken_i(br), .mem_req_i(req), .mem_ack_i(ack),
        .pc_write_o(a_pc), .IF_ID_write_o(a_ifid),
        .IF_flush_o(a_fl), .ID_EX_bubble_o(a_bub),
        .freeze_o(a_frz), .mem_timeout_o(a_to),
        .stall_cnt_o(a_cnt)
    );

    hazard_stall_ctrl #(
        .LU_CYCLES(3), .MEM_TIMEOUT(8), .CNT_W(4)
    ) u_b (
        .clk_i(clk), .rst_i(rst),
        .ID_EX_MemRead_i(mr), .ID_EX_RegisterRt_i(ert),
        .IF_ID_RegisterRs_i(rs), .IF_ID_RegisterRt_i(rt),
        .branch_taken_i(br), .mem_req_i(req), .mem_ack_i(ack),
        .pc_write_o(b_pc), .IF_ID_write_o(b_ifid),
        .IF_flush_o(b_fl), .ID_EX_bubble_o(b_bub),
        .freeze_o(b_frz), .mem_timeout_o(b_to),
        .stall_cnt_o(b_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [21:0] obs(input bit sel);
        if (sel) return {b_pc, b_ifid, b_fl, b_bub, b_frz, b_to, 12'd0, b_cnt};
        return {a_pc, a_ifid, a_fl, a_bub, a_frz, a_to, a_cnt};
    endfunction

    task automatic drive(input logic m, input logic [4:0] e,
                         input logic [4:0] s, input logic [4:0] t,
                         input logic b, input logic q, input logic k);
        mr = m; ert = e; rs = s; rt = t;
        br = b; req = q; ack = k;
    endtask

    task automatic push(input bit sel, input logic [5:0] o,
                        input logic [15:0] c);
        exp_t e;
        e.sel = sel; e.o = o; e.c = c;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        logic [21:0] got;
        rst = 1'b1;
        drive(1, 2, 2, 2, 1, 1, 0);
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            case (i)
                0, 2: begin drive(1, 2, 2, 2, 1, 1, 0); push(0, RUNV, 0); end
                1, 3: begin drive(1, 2, 2, 2, 1, 1, 0); push(1, RUNV, 0); end
                4: begin rst = 1'b0; drive(1, 4, 4, 0, 0, 0, 0); push(1, LUV, 0); end
                5: begin rst = 1'b1; drive(0, 0, 0, 0, 0, 0, 0); push(1, RUNV, 1); end
                6: begin rst = 1'b0; push(1, RUNV, 0); end
                default: push(1, RUNV, 0);
            endcase
            @(negedge clk);
            e = sb.pop_front();
            got = obs(e.sel);
            checks++;
            if (got !== {e.o, e.c}) begin
                errors++;
                $display("FAIL reset[%0d] dut%0d: got %b/%0d expected %b/%0d",
                         i, e.sel, got[21:16], got[15:0], e.o, e.c);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        exp_t e;
        logic [21:0] got;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            case (i)
                0: begin drive(1, 2, 2, 4, 0, 0, 0); push(0, LUV, 0); end
                1: begin drive(0, 2, 2, 4, 0, 0, 0); push(0, RUNV, 1); end
                2: begin drive(1, 0, 0, 3, 0, 0, 0); push(0, RUNV, 1); end
                3: begin drive(1, 5, 6, 7, 0, 0, 0); push(0, RUNV, 1); end
                4: begin drive(0, 9, 9, 9, 0, 0, 0); push(0, RUNV, 1); end
                5: begin drive(1, 9, 1, 9, 0, 0, 0); push(0, LUV, 1); end
                default: begin drive(0, 0, 0, 0, 0, 0, 0); push(0, RUNV, 2); end
            endcase
            @(negedge clk);
            e = sb.pop_front();
            got = obs(e.sel);
            checks++;
            if (got !== {e.o, e.c}) begin
                errors++;
                $display("FAIL load_use[%0d] dut%0d: got %b/%0d expected %b/%0d",
                         i, e.sel, got[21:16], got[15:0], e.o, e.c);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lu_multi();
        exp_t e;
        logic [21:0] got;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i == 0) drive(1, 3, 3, 0, 0, 0, 0);
            else drive(0, 0, 0, 0, 0, 0, 0);
            if (i < 3) push(1, LUV, 16'(i));
            else push(1, RUNV, 3);
            @(negedge clk);
            e = sb.pop_front();
            got = obs(e.sel);
            checks++;
            if (got !== {e.o, e.c}) begin
                errors++;
                $display("FAIL lu_multi[%0d] dut%0d: got %b/%0d expected %b/%0d",
                         i, e.sel, got[21:16], got[15:0], e.o, e.c);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mem_wait();
        exp_t e;
        logic [21:0] got;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            case (i)
                0, 1, 2, 3: begin drive(0, 0, 0, 0, 0, 1, 0); push(0, FRZ, 16'(i)); end
                4: begin drive(0, 0, 0, 0, 0, 1, 1); push(0, RUNV, 4); end
                5: begin drive(0, 0, 0, 0, 0, 0, 1); push(0, RUNV, 4); end
                default: begin drive(0, 0, 0, 0, 0, 0, 0); push(0, RUNV, 4); end
            endcase
            @(negedge clk);
            e = sb.pop_front();
            got = obs(e.sel);
            checks++;
            if (got !== {e.o, e.c}) begin
                errors++;
                $display("FAIL mem_wait[%0d] dut%0d: got %b/%0d expected %b/%0d",
                         i, e.sel, got[21:16], got[15:0], e.o, e.c);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        exp_t e;
        logic [21:0] got;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: begin drive(1, 2, 2, 0, 1, 0, 0); push(0, LUV, 0); end
                1: begin drive(0, 2, 2, 0, 1, 0, 0); push(0, FLV, 1); end
                2: begin drive(0, 0, 0, 0, 0, 0, 0); push(0, RUNV, 1); end
                3: begin drive(0, 0, 0, 0, 1, 1, 0); push(0, FRZ, 1); end
                4: begin drive(0, 0, 0, 0, 1, 1, 1); push(0, FLV, 2); end
                default: begin drive(0, 0, 0, 0, 0, 0, 0); push(0, RUNV, 2); end
            endcase
            @(negedge clk);
            e = sb.pop_front();
            got = obs(e.sel);
            checks++;
            if (got !== {e.o, e.c}) begin
                errors++;
                $display("FAIL branch[%0d] dut%0d: got %b/%0d expected %b/%0d",
                         i, e.sel, got[21:16], got[15:0], e.o, e.c);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [21:0] got;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: begin drive(1, 7, 0, 7, 0, 0, 0); push(1, LUV, 0); end
                1: begin drive(0, 0, 0, 0, 0, 1, 0); push(1, FRZ, 1); end
                2: begin drive(0, 0, 0, 0, 0, 1, 1); push(1, RUNV, 2); end
                3: begin drive(0, 0, 0, 0, 0, 0, 0); push(1, LUV, 2); end
                4: push(1, LUV, 3);
                default: push(1, RUNV, 4);
            endcase
            @(negedge clk);
            e = sb.pop_front();
            got = obs(e.sel);
            checks++;
            if (got !== {e.o, e.c}) begin
                errors++;
                $display("FAIL back_to_back[%0d] dut%0d: got %b/%0d expected %b/%0d",
                         i, e.sel, got[21:16], got[15:0], e.o, e.c);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        logic [21:0] got;
        do_reset();
        for (int i = 0; i < 24; i++) begin
            if (i < 20) begin
                drive(0, 0, 0, 0, 0, 1, 0);
                push(1, FRZ | ((i >= 8) ? 6'd1 : 6'd0), (i > 15) ? 16'd15 : 16'(i));
            end else if (i == 20) begin
                drive(0, 0, 0, 0, 0, 1, 1);
                push(1, RUNV | 6'd1, 15);
            end else if (i == 21) begin
                drive(0, 0, 0, 0, 0, 0, 0);
                push(1, RUNV | 6'd1, 15);
            end else begin
                if (i == 22) do_reset();
                push(1, RUNV, 0);
            end
            @(negedge clk);
            e = sb.pop_front();
            got = obs(e.sel);
            checks++;
            if (got !== {e.o, e.c}) begin
                errors++;
                $display("FAIL timeout[%0d] dut%0d: got %b/%0d expected %b/%0d",
                         i, e.sel, got[21:16], got[15:0], e.o, e.c);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_load_use();
        test_lu_multi();
        test_mem_wait();
        test_branch();
        test_back_to_back();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
